// File: rtl/seg_scroll_pkg.sv
// Shared types, 7-segment hex font and sizing helpers for the digit scroller.
package seg_scroll_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Indexed by nibble value; bit0 = segment a .. bit6 = segment g.
  localparam logic [6:0] HEX_FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic int timer_width(input int dwell_cycles, input int gap_cycles);
    int longest;
    longest = (dwell_cycles > gap_cycles) ? dwell_cycles : gap_cycles;
    return (longest > 1) ? $clog2(longest) : 1;
  endfunction

  function automatic int index_width(input int num_digits);
    return (num_digits > 1) ? $clog2(num_digits) : 1;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to 7-segment pattern lookup (active-high, bit0 = a).
module seg7_hex_decode
  import seg_scroll_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segments
);

  assign segments = HEX_FONT[nibble];

endmodule

// File: rtl/seg_digit_scroller.sv
// Scrolls a multi-digit hex value across one 7-segment display, MSD first.
// Optional SEG_SCROLL_LEAD_BLANK_EN: start at the highest nonzero nibble.
module seg_digit_scroller
  import seg_scroll_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 10000000,
  parameter int GAP_CYCLES   = 1000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  output logic                    load_ready,
  input  logic                    repeat_en,
  output logic [6:0]              segments,
  output logic                    dp,
  output logic                    busy
);

  localparam int DATA_W  = 4 * NUM_DIGITS;
  localparam int IDX_W   = index_width(NUM_DIGITS);
  localparam int TIMER_W = timer_width(DWELL_CYCLES, GAP_CYCLES);

  localparam logic [IDX_W-1:0]   TOP_IDX    = IDX_W'(NUM_DIGITS - 1);
  localparam logic [TIMER_W-1:0] DWELL_LAST = TIMER_W'(DWELL_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GAP_LAST   = TIMER_W'(GAP_CYCLES - 1);

  state_t              state_reg, state_next;
  logic [IDX_W-1:0]    index_reg, index_next;
  logic [TIMER_W-1:0]  timer_reg, timer_next;
  logic [DATA_W-1:0]   data_reg, data_next;
  logic [6:0]          segments_reg;
  logic                dp_reg, busy_reg, load_ready_reg;
  logic [IDX_W-1:0]    start_idx;
  logic [3:0]          nibble_next;
  logic [6:0]          font_next;

`ifdef SEG_SCROLL_LEAD_BLANK_EN
  logic [NUM_DIGITS-1:0] nibble_nz;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nz
      assign nibble_nz[gi] = |load_data[4*gi +: 4];
    end
  endgenerate

  // An all-zero value still falls through to index 0, showing a single "0".
  always_comb begin
    start_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (nibble_nz[i]) start_idx = IDX_W'(i);
    end
  end
`else
  assign start_idx = TOP_IDX;
`endif

  always_comb begin
    state_next = state_reg;
    index_next = index_reg;
    timer_next = timer_reg;
    data_next  = data_reg;
    unique case (state_reg)
      IDLE: begin
        if (load_valid && load_ready_reg) begin
          data_next  = load_data;
          index_next = start_idx;
          timer_next = '0;
          state_next = SHOW;
        end
      end
      SHOW: begin
        if (timer_reg == DWELL_LAST) begin
          timer_next = '0;
          state_next = GAP;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      GAP: begin
        if (timer_reg == GAP_LAST) begin
          timer_next = '0;
          if (index_reg != '0) begin
            index_next = index_reg - 1'b1;
            state_next = SHOW;
          end else if (repeat_en) begin
            index_next = TOP_IDX;
            state_next = SHOW;
          end else begin
            state_next = IDLE;
          end
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Decode from the next-state digit so the registered outputs track the FSM
  // without an extra cycle of latency.
  assign nibble_next = data_next[{index_next, 2'b00} +: 4];

  seg7_hex_decode u_decode (
    .nibble   (nibble_next),
    .segments (font_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      index_reg      <= '0;
      timer_reg      <= '0;
      data_reg       <= '0;
      segments_reg   <= '0;
      dp_reg         <= 1'b0;
      busy_reg       <= 1'b0;
      load_ready_reg <= 1'b1;
    end else begin
      state_reg      <= state_next;
      index_reg      <= index_next;
      timer_reg      <= timer_next;
      data_reg       <= data_next;
      segments_reg   <= (state_next == SHOW) ? font_next : 7'h00;
      dp_reg         <= (state_next == SHOW) && (index_next == '0);
      busy_reg       <= (state_next != IDLE);
      load_ready_reg <= (state_next == IDLE);
    end
  end

  assign segments   = segments_reg;
  assign dp         = dp_reg;
  assign busy       = busy_reg;
  assign load_ready = load_ready_reg;

endmodule

// File: tb/tb_seg_digit_scroller.sv
// Randomized bench for seg_digit_scroller; a queue of expected display frames
// is the reference model.
module tb_seg_digit_scroller;

  localparam int ND    = 4;
  localparam int DWELL = 4;
  localparam int GAPC  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_valid = 1'b0;
  logic [15:0]   load_data = '0;
  logic          load_ready;
  logic          repeat_en = 1'b0;
  logic [6:0]    segments;
  logic          dp;
  logic          busy;

  always #5 clk = ~clk;

  seg_digit_scroller #(
    .NUM_DIGITS   (ND),
    .DWELL_CYCLES (DWELL),
    .GAP_CYCLES   (GAPC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .repeat_en  (repeat_en),
    .segments   (segments),
    .dp         (dp),
    .busy       (busy)
  );

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
  } frame_t;

  logic [6:0] font [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  frame_t      frames[$];
  logic [15:0] model_data = '0;
  bit          accepted;
  int          checks_total = 0;
  int          checks_passed = 0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks_total++;
    if (observed !== expected)
      $display("FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
    else
      checks_passed++;
  endtask

  // Every frame the display should show, one per clock, from digit 'start' down to 0.
  function automatic void push_sequence(input logic [15:0] v, input int start);
    frame_t f;
    for (int d = start; d >= 0; d--) begin
      f.seg = font[v[4*d +: 4]];
      f.dp  = (d == 0);
      for (int k = 0; k < DWELL; k++) frames.push_back(f);
      f = '0;
      for (int k = 0; k < GAPC; k++) frames.push_back(f);
    end
  endfunction

  function automatic int first_digit(input logic [15:0] v);
    int s;
`ifdef SEG_SCROLL_LEAD_BLANK_EN
    s = 0;
    for (int d = 0; d < ND; d++) if (v[4*d +: 4] != 4'h0) s = d;
`else
    s = ND - 1;
    if (v == 16'hFFFF) s = ND - 1;
`endif
    return s;
  endfunction

  // Advance one clock, update the model with the inputs seen at that edge, compare.
  task automatic step();
    frame_t done;
    @(posedge clk);
    accepted = 1'b0;
    if (rst) begin
      frames.delete();
    end else if (frames.size() == 0) begin
      if (load_valid) begin
        model_data = load_data;
        push_sequence(load_data, first_digit(load_data));
        accepted = 1'b1;
        $display("load %h repeat_en=%0b accepted at %0t", load_data, repeat_en, $time);
      end
    end else begin
      done = frames.pop_front();
      if (frames.size() == 0 && repeat_en) push_sequence(model_data, ND - 1);
    end
    #1;
    if (frames.size() == 0) begin
      check("segments", 32'(segments), 32'h00);
      check("dp", 32'(dp), 32'd0);
      check("busy", 32'(busy), 32'd0);
      check("load_ready", 32'(load_ready), 32'd1);
    end else begin
      check("segments", 32'(segments), 32'(frames[0].seg));
      check("dp", 32'(dp), 32'(frames[0].dp));
      check("busy", 32'(busy), 32'd1);
      check("load_ready", 32'(load_ready), 32'd0);
    end
  endtask

  // Present a value and hold it until the model says it was taken.
  task automatic load_value(input logic [15:0] v, input string tag);
    int n;
    load_valid = 1'b1;
    load_data  = v;
    n = 0;
    do begin
      step();
      n++;
    end while (!accepted && n < 200);
    if (!accepted) check({tag, "_accept_timeout"}, 32'd0, 32'd1);
    load_valid = 1'b0;
  endtask

  task automatic run_until_idle(input string tag);
    int n;
    n = 0;
    while (frames.size() != 0 && n < 300) begin
      step();
      n++;
    end
    if (frames.size() != 0) check({tag, "_idle_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int busy_cnt;
    int wait_len;

    // Reset, with a load_valid presented alongside it that must be ignored.
    rst = 1'b1;
    load_valid = 1'b1;
    load_data = 16'h1234;
    step();
    step();
    load_valid = 1'b0;
    rst = 1'b0;
    step();

    // Plain one-shot scroll and busy length.
    repeat_en = 1'b0;
    load_value(16'h1A3F, "d1");
    busy_cnt = busy ? 1 : 0;
    for (int i = 0; i < 28; i++) begin
      step();
      if (busy) busy_cnt++;
    end
`ifdef SEG_SCROLL_LEAD_BLANK_EN
    check("busy_len_1a3f", 32'(busy_cnt), 32'd24);
`else
    check("busy_len_1a3f", 32'(busy_cnt), 32'd24);
`endif

    // Repeat mode, dropped during the second pass.
    repeat_en = 1'b1;
    load_value(16'h00F0, "d2");
    for (int i = 0; i < 30; i++) step();
    repeat_en = 1'b0;
    run_until_idle("d2");
    step();

    // Load held while busy is taken in the first idle cycle.
    load_value(16'h1234, "d3a");
    load_valid = 1'b1;
    load_data  = 16'hBEEF;
    wait_len = 0;
    do begin
      step();
      wait_len++;
    end while (!accepted && wait_len < 200);
    check("beef_accepted", 32'(accepted), 32'd1);
    check("beef_first", 32'(segments), 32'h7C);
    load_valid = 1'b0;
    run_until_idle("d3");

    // Reset inside the gap after the second digit, then a fresh load.
    load_value(16'h5678, "d4");
    for (int i = 0; i < 10; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_gap_busy", 32'(busy), 32'd0);
    load_value(16'h0008, "d4b");
    run_until_idle("d4b");
    load_value(16'h0000, "d5");
    run_until_idle("d5");

    // Randomized loads, repeat toggling and occasional resets.
    for (int it = 0; it < 40; it++) begin
      logic [15:0] v;
      int len;
      v = 16'($urandom);
      if ($urandom_range(0, 2) == 0) v = v & 16'($urandom_range(0, 16'hFFFF) >> $urandom_range(0, 15));
      repeat_en = 1'($urandom_range(0, 1));
      load_value(v, "rnd");
      len = $urandom_range(0, 40);
      for (int c = 0; c < len; c++) begin
        rst = ($urandom_range(0, 29) == 0);
        if ($urandom_range(0, 7) == 0) repeat_en = ~repeat_en;
        if ($urandom_range(0, 9) == 0) begin
          load_valid = 1'b1;
          load_data  = 16'($urandom);
        end
        step();
        load_valid = 1'b0;
        rst = 1'b0;
      end
      repeat_en = 1'b0;
      run_until_idle("rnd");
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
